alu_result_buffer: RTL
======================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of entries; power of two, 2..16.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port: in_ready  output  1  buffer can accept a push.
REQ-006 SHALL have port: y  input  8  ALU result word.
REQ-007 SHALL have ports: parity, overflow, greater, is_eq, less  input  1 each  ALU flags.
REQ-008 SHALL have port: out_valid  output  1  head entry available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port: out_data  output  13  head entry {less, is_eq, greater, overflow, parity, y[7:0]}, MSB first.
REQ-011 SHALL have port: level  output  5  current occupancy, 0..DEPTH.
REQ-012 SHALL have ports: eq_count, ovf_count  output  8 each  statistics counters.

Function
REQ-013 SHALL push the 13-bit tuple at a rising edge when in_valid && in_ready.
REQ-014 SHALL pop the head entry at a rising edge when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (level != DEPTH), from registered state only; no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (level != 0), from registered state only.
REQ-017 SHALL present out_data directly from the head storage slot; a push into an empty buffer at edge N is visible on out_data/out_valid after edge N (1-cycle latency).
REQ-018 SHALL hold out_data stable while out_valid && !out_ready.
REQ-019 SHALL deliver entries in push order (FIFO), with read/write pointers wrapping modulo DEPTH.
REQ-020 SHALL, on simultaneous push and pop with 0 < level < DEPTH, leave level unchanged and advance both pointers.
REQ-021 SHALL, when full, refuse a push even if a pop occurs in the same cycle; level becomes DEPTH-1.
REQ-022 SHALL ignore out_ready when empty and ignore in_valid when full; no state change, no error.
REQ-023 SHALL treat out_data as don't-care when out_valid is 0.
REQ-024 SHALL increment eq_count on each accepted push with is_eq = 1, saturating at 255.
REQ-025 SHALL increment ovf_count on each accepted push with overflow = 1, saturating at 255.
REQ-026 SHALL count at push time, independent of pops.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear pointers, level, eq_count, ovf_count; in_ready = 1, out_valid = 0.
REQ-028 SHALL discard all buffered entries on reset asserted mid-operation; storage contents need not be cleared.
REQ-029 SHALL accept the first push at the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile the statistics counters only when macro ALU_RESULT_BUFFER_STATS_EN is defined.
REQ-031 SHALL, without ALU_RESULT_BUFFER_STATS_EN, tie eq_count and ovf_count to 8'h00 with no counter flops; FIFO behaviour unchanged.

Verification
REQ-032 SHALL cover: reset, push y=8'hA5 with parity=1 -> next cycle out_valid=1, out_data=13'h01A5, level=1.
REQ-033 SHALL cover: 4 pushes, out_ready=0 -> level=4, in_ready=0; 5th push ignored; drain -> 4 words in order.
REQ-034 SHALL cover: full, in_valid=1 and out_ready=1 together -> level=3, pushed word not stored.
REQ-035 SHALL cover: level=2, push and pop together for 10 cycles -> level stays 2, order preserved across pointer wrap.
REQ-036 SHALL cover: 300 pushes with is_eq=1, out_ready=1 -> eq_count=255 with macro, 0 without.
REQ-037 SHALL cover: rst_n pulsed low mid-burst at level=3 -> immediately out_valid=0, level=0, counters 0.

Source files
------------

// File: rtl/alu_result_buffer.sv
// ============================================================================
// Module   : alu_result_buffer
// Summary  : FIFO for ALU results and their flags, with optional push-time
//            statistics counters enabled by macro ALU_RESULT_BUFFER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  y,
    input  logic        parity,
    input  logic        overflow,
    input  logic        greater,
    input  logic        is_eq,
    input  logic        less,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic [4:0]  level,
    output logic [7:0]  eq_count,
    output logic [7:0]  ovf_count
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] C_DEPTH = 5'(DEPTH);
    localparam logic [7:0] C_SAT   = 8'hFF;

    logic [12:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_level;

    logic             w_push;
    logic             w_pop;
    logic [12:0]      w_entry;

    assign w_entry   = {less, is_eq, greater, overflow, parity, y};

    // Handshakes come purely from the occupancy register, so out_ready never
    // reaches in_ready: a full buffer refuses a push even while it pops.
    assign in_ready  = (r_level != C_DEPTH);
    assign out_valid = (r_level != 5'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_data  = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 5'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef ALU_RESULT_BUFFER_STATS_EN
    logic [7:0] r_eq_count;
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_count  <= 8'h00;
            r_ovf_count <= 8'h00;
        end else if (w_push) begin
            if (is_eq && (r_eq_count != C_SAT)) begin
                r_eq_count <= r_eq_count + 8'd1;
            end
            if (overflow && (r_ovf_count != C_SAT)) begin
                r_ovf_count <= r_ovf_count + 8'd1;
            end
        end
    end

    assign eq_count  = r_eq_count;
    assign ovf_count = r_ovf_count;
`else
    assign eq_count  = 8'h00;
    assign ovf_count = 8'h00;
`endif

endmodule

`default_nettype wire
